// File: rtl/service_4_minigame_multi_pkg.sv
// service_4_pkg: shared definitions for the Service 4 alarm-dismiss minigame.
//   - one-hot state encodings (7 bits) and the state enum built from them
//   - default widths for the switch bank, streak counter and miss counter
//   - is_onehot(): true when exactly one bit of a vector is set
package service_4_pkg;

    localparam int DEF_N_SW   = 10;
    localparam int DEF_CWIDTH = 16;
    localparam int DEF_MWIDTH = 8;

    // Widest switch bank is_onehot() can inspect; narrower vectors are zero-extended.
    localparam int MAX_SW = 64;

    localparam logic [6:0] ST_IDLE     = 7'b000_0001;
    localparam logic [6:0] ST_ARM      = 7'b000_0010;
    localparam logic [6:0] ST_SHOW     = 7'b000_0100;
    localparam logic [6:0] ST_HOLD     = 7'b000_1000;
    localparam logic [6:0] ST_RELEASE  = 7'b001_0000;
    localparam logic [6:0] ST_DONE     = 7'b010_0000;
    localparam logic [6:0] ST_WAIT_CLR = 7'b100_0000;

    typedef enum logic [6:0] {
        IDLE     = ST_IDLE,
        ARM      = ST_ARM,
        SHOW     = ST_SHOW,
        HOLD     = ST_HOLD,
        RELEASE  = ST_RELEASE,
        DONE     = ST_DONE,
        WAIT_CLR = ST_WAIT_CLR
    } state_t;

    function automatic logic is_onehot(input logic [MAX_SW-1:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/service_4_minigame_multi_if.sv
// Minigame bus: alarm/generator/switch inputs and all game status outputs.
//   master : drives alarm_ring, random_led, SPDTs; observes the game outputs
//   slave  : the minigame itself
interface service_4_minigame_multi_if #(
    parameter int N_SW   = 10,
    parameter int CWIDTH = 16,
    parameter int MWIDTH = 8
);
    logic              alarm_ring;
    logic [N_SW-1:0]   random_led;
    logic [N_SW-1:0]   SPDTs;
    logic              mini_game;
    logic [N_SW-1:0]   target_led;
    logic [CWIDTH-1:0] count_state;
    logic [MWIDTH-1:0] miss_count;
    logic              miss_pulse;
    logic              game_done;

    modport master (
        output alarm_ring, random_led, SPDTs,
        input  mini_game, target_led, count_state, miss_count, miss_pulse, game_done
    );

    modport slave (
        input  alarm_ring, random_led, SPDTs,
        output mini_game, target_led, count_state, miss_count, miss_pulse, game_done
    );
endinterface

// File: rtl/service_4_round_timer.sv
// Round timer and settle counter for the minigame.
//   clk, reset : clock, synchronous active-high reset
//   tmr_clr    : zero the round timer (new target latched)
//   tmr_en     : advance the round timer (saturates at ROUND_TICKS-1)
//   tmr_tc     : the increment made this cycle reaches ROUND_TICKS-1
//   set_clr    : zero the settle counter (switches not on target)
//   set_inc    : count one more matching cycle
//   set_tc     : the current matching cycle is the SETTLE-th one
module service_4_round_timer #(
    parameter int ROUND_TICKS = 100,
    parameter int SETTLE      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tmr_clr,
    input  logic tmr_en,
    output logic tmr_tc,
    input  logic set_clr,
    input  logic set_inc,
    output logic set_tc
);
    localparam int TW = (ROUND_TICKS > 2) ? $clog2(ROUND_TICKS) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [TW-1:0] TMR_MAX  = TW'(ROUND_TICKS - 1);
    localparam logic [TW-1:0] TMR_WARN = TW'(ROUND_TICKS - 2);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SET_MAX  = SW'(SETTLE);

    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] settle_q, settle_d;

    always_comb begin
        tmr_d = tmr_q;
        if (tmr_clr) begin
            tmr_d = '0;
        end else if (tmr_en && tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TW'(1);
        end

        settle_d = settle_q;
        if (set_clr) begin
            settle_d = '0;
        end else if (set_inc && settle_q != SET_MAX) begin
            settle_d = settle_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q    <= '0;
            settle_q <= '0;
        end else begin
            tmr_q    <= tmr_d;
            settle_q <= settle_d;
        end
    end

    // ">=" so a round that spent long in HOLD still times out once back in SHOW.
    assign tmr_tc = (tmr_q >= TMR_WARN);
    assign set_tc = (settle_q == SET_LAST);

endmodule

// File: rtl/service_4_minigame_multi.sv
// Alarm-dismiss minigame: shows one-hot LED targets while the alarm rings;
// WIN_COUNT consecutive matches (each held SETTLE cycles) dismiss it.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : alarm_ring/random_led/SPDTs in; mini_game, target_led,
//                count_state, miss_count, miss_pulse, game_done out (all registered)
module service_4_minigame_multi
    import service_4_pkg::*;
#(
    parameter int N_SW        = DEF_N_SW,
    parameter int WIN_COUNT   = 3,
    parameter int ROUND_TICKS = 100,
    parameter int SETTLE      = 4,
    parameter int CWIDTH      = DEF_CWIDTH,
    parameter int MWIDTH      = DEF_MWIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    service_4_minigame_multi_if.slave bus
);
    if (WIN_COUNT < 1 || WIN_COUNT >= (2 ** CWIDTH)) begin : g_bad_win_count
        $error("WIN_COUNT must be >= 1 and fit in CWIDTH bits");
    end
    if (N_SW < 1 || N_SW > MAX_SW) begin : g_bad_n_sw
        $error("N_SW out of supported range");
    end

    localparam int RW = (N_SW > 1) ? $clog2(N_SW) : 1;
    localparam logic [CWIDTH-1:0] WIN = CWIDTH'(WIN_COUNT);

    state_t            state_q, state_d;
    logic              mini_game_q, mini_game_d;
    logic [N_SW-1:0]   target_q, target_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [MWIDTH-1:0] miss_q, miss_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              game_done_q, game_done_d;
    logic [RW-1:0]     round_q, round_d;   // round index already reduced mod N_SW

    logic tmr_clr, tmr_en, tmr_tc, set_clr, set_inc, set_tc;
    logic match, sw_zero, latch, do_score, do_miss, abort;

    service_4_round_timer #(
        .ROUND_TICKS(ROUND_TICKS),
        .SETTLE     (SETTLE)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tmr_clr(tmr_clr),
        .tmr_en (tmr_en),
        .tmr_tc (tmr_tc),
        .set_clr(set_clr),
        .set_inc(set_inc),
        .set_tc (set_tc)
    );

    assign match   = (bus.SPDTs == target_q);
    assign sw_zero = (bus.SPDTs == '0);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        miss_d   = miss_q;
        round_d  = round_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        set_clr  = 1'b1;
        set_inc  = 1'b0;
        latch    = 1'b0;
        do_score = 1'b0;
        do_miss  = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.alarm_ring) begin
                    state_d = ARM;
                    count_d = '0;
                    miss_d  = '0;
                end
            end
            ARM: begin
                if (!bus.alarm_ring) abort = 1'b1;
                else if (sw_zero)    latch = 1'b1;
            end
            SHOW: begin
                if (!bus.alarm_ring) begin
                    abort = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    // A match is tested before the timeout so it wins a tie.
                    if (match) begin
                        if (set_tc) begin
                            do_score = 1'b1;
                        end else begin
                            set_clr = 1'b0;
                            set_inc = 1'b1;
                            state_d = HOLD;
                        end
                    end else if (!sw_zero || tmr_tc) begin
                        do_miss = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!bus.alarm_ring) begin
                    abort = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (match) begin
                        if (set_tc) begin
                            do_score = 1'b1;
                        end else begin
                            set_clr = 1'b0;
                            set_inc = 1'b1;
                        end
                    end else if (sw_zero) begin
                        state_d = SHOW;   // bounce: keep target and running timer
                    end else begin
                        do_miss = 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!bus.alarm_ring) abort = 1'b1;
                else if (sw_zero)    latch = 1'b1;
            end
            DONE: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!bus.alarm_ring) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (latch) begin
            state_d  = SHOW;
            tmr_clr  = 1'b1;
            target_d = is_onehot(MAX_SW'(bus.random_led)) ? bus.random_led
                                                           : (N_SW'(1) << round_q);
            round_d  = (round_q == RW'(N_SW - 1)) ? '0 : round_q + RW'(1);
        end

        if (do_score) begin
            count_d  = count_q + CWIDTH'(1);
            target_d = '0;
            state_d  = (count_d == WIN) ? DONE : RELEASE;
        end

        if (do_miss) begin
            count_d  = '0;
            target_d = '0;
            state_d  = RELEASE;
            if (miss_q != '1) miss_d = miss_q + MWIDTH'(1);
        end

        if (abort) begin
            state_d  = IDLE;
            target_d = '0;
            count_d  = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        mini_game_d  = (state_d != IDLE) && (state_d != WAIT_CLR);
        game_done_d  = (state_d == DONE);
        miss_pulse_d = do_miss;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mini_game_q  <= 1'b0;
            target_q     <= '0;
            count_q      <= '0;
            miss_q       <= '0;
            miss_pulse_q <= 1'b0;
            game_done_q  <= 1'b0;
            round_q      <= '0;
        end else begin
            state_q      <= state_d;
            mini_game_q  <= mini_game_d;
            target_q     <= target_d;
            count_q      <= count_d;
            miss_q       <= miss_d;
            miss_pulse_q <= miss_pulse_d;
            game_done_q  <= game_done_d;
            round_q      <= round_d;
        end
    end

    assign bus.mini_game   = mini_game_q;
    assign bus.target_led  = target_q;
    assign bus.count_state = count_q;
    assign bus.miss_count  = miss_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.game_done   = game_done_q;

endmodule

// File: tb/tb_service_4_minigame_multi.sv
// Directed bench for service_4_minigame_multi with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_service_4_minigame_multi;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    service_4_minigame_multi_if #(.N_SW(10), .CWIDTH(16), .MWIDTH(8)) bus ();

    service_4_minigame_multi #(
        .N_SW       (10),
        .WIN_COUNT  (3),
        .ROUND_TICKS(100),
        .SETTLE     (4),
        .CWIDTH     (16),
        .MWIDTH     (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Match the current target for SETTLE (4) cycles.
    task automatic hold_target(input logic [9:0] t);
        bus.SPDTs = t;
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.alarm_ring = 1'b0;
        bus.random_led = 10'b1;
        bus.SPDTs      = '0;
        step(3);

        // ---- reset state
        check("rst_mini_game",  32'(bus.mini_game), 0);
        check("rst_target",     32'(bus.target_led), 0);
        check("rst_count",      32'(bus.count_state), 0);
        check("rst_miss",       32'(bus.miss_count), 0);
        check("rst_game_done",  32'(bus.game_done), 0);
        reset = 1'b0;
        step(1);

        // ---- win path
        bus.alarm_ring = 1'b1;
        step(1);
        check("arm_mini_game", 32'(bus.mini_game), 1);
        check("arm_target",    32'(bus.target_led), 0);
        step(1);
        check("show1_target",  32'(bus.target_led), 1);
        hold_target(10'b1);
        check("win_count1",    32'(bus.count_state), 1);
        check("win_rel_target",32'(bus.target_led), 0);
        bus.SPDTs = '0;
        step(1);
        check("show2_target",  32'(bus.target_led), 1);
        hold_target(10'b1);
        check("win_count2",    32'(bus.count_state), 2);
        bus.SPDTs = '0;
        step(1);
        hold_target(10'b1);
        check("win_count3",    32'(bus.count_state), 3);
        check("win_game_done", 32'(bus.game_done), 1);
        check("win_mini_still",32'(bus.mini_game), 1);
        bus.SPDTs = '0;
        step(1);
        check("done_pulse_end",32'(bus.game_done), 0);
        check("done_mini_drop",32'(bus.mini_game), 0);
        check("done_count_hold",32'(bus.count_state), 3);
        step(3);
        check("waitclr_no_restart", 32'(bus.mini_game), 0);

        // ---- ring toggles low then high: new game, streak/misses cleared
        bus.alarm_ring = 1'b0;
        step(1);
        bus.random_led = 10'b10_0000;
        bus.alarm_ring = 1'b1;
        step(1);
        check("rearm_mini",    32'(bus.mini_game), 1);
        check("rearm_count",   32'(bus.count_state), 0);
        step(1);
        check("wrong_target",  32'(bus.target_led), 32'h20);

        // ---- wrong switch
        bus.SPDTs = 10'b01_0000;
        step(1);
        check("wrong_pulse",   32'(bus.miss_pulse), 1);
        check("wrong_miss_cnt",32'(bus.miss_count), 1);
        check("wrong_count",   32'(bus.count_state), 0);
        step(1);
        check("wrong_pulse_1cyc", 32'(bus.miss_pulse), 0);
        check("wrong_rel_target", 32'(bus.target_led), 0);
        bus.SPDTs = '0;
        step(1);
        check("after_rel_target", 32'(bus.target_led), 32'h20);

        // ---- timeout: SHOW entered at the edge just before this sample
        step(98);
        check("timeout_not_yet", 32'(bus.miss_pulse), 0);
        bus.random_led = 10'b00_0000_1000;
        step(1);
        check("timeout_pulse",   32'(bus.miss_pulse), 1);
        check("timeout_miss_cnt",32'(bus.miss_count), 2);
        step(1);
        check("timeout_new_target", 32'(bus.target_led), 8);

        // ---- settle bounce: 2 matching cycles, release, then 4 matching
        bus.SPDTs = 10'd8;
        step(2);
        bus.SPDTs = '0;
        step(1);
        check("bounce_target", 32'(bus.target_led), 8);
        check("bounce_count0", 32'(bus.count_state), 0);
        hold_target(10'd8);
        check("bounce_count1", 32'(bus.count_state), 1);
        check("bounce_no_miss",32'(bus.miss_count), 2);

        // ---- abort during HOLD
        bus.SPDTs = '0;
        step(1);
        bus.SPDTs = 10'd8;
        step(1);
        bus.alarm_ring = 1'b0;
        step(1);
        check("abort_mini",    32'(bus.mini_game), 0);
        check("abort_target",  32'(bus.target_led), 0);
        check("abort_count",   32'(bus.count_state), 0);
        check("abort_done",    32'(bus.game_done), 0);
        check("abort_miss_held", 32'(bus.miss_count), 2);
        bus.SPDTs = '0;

        // ---- reset mid-SHOW
        bus.random_led = 10'b1;
        bus.alarm_ring = 1'b1;
        step(2);
        check("pre_rst_target", 32'(bus.target_led), 1);
        reset = 1'b1;
        step(1);
        check("midrst_mini",   32'(bus.mini_game), 0);
        check("midrst_target", 32'(bus.target_led), 0);
        reset = 1'b0;

        // ---- fallback target on non-one-hot random_led at round 3
        step(2);
        check("fb_round1_target", 32'(bus.target_led), 1);
        hold_target(10'b1);
        bus.SPDTs = '0;
        step(1);
        hold_target(10'b1);
        check("fb_count2",     32'(bus.count_state), 2);
        bus.random_led = 10'b0;
        bus.SPDTs = '0;
        step(1);
        check("fb_round3_target", 32'(bus.target_led), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/service_4_minigame_multi.md
Name: service_4_minigame_multi

Overview:
Parametrised alarm-dismiss minigame for Service 4. While the alarm rings, it presents a sequence of one-hot LED targets. The user must match each target on the SPDT switches and hold it for a settle time. A configurable number of consecutive correct matches dismisses the alarm. It adds a per-round timeout, switch-release gating, miss counting, and abort on alarm cancel. It sits between the alarm checker (drives alarm_ring) and the random LED generator (drives random_led).

Parameters:
N_SW, 10, number of switches/LEDs (target width)
WIN_COUNT, 3, consecutive correct rounds needed to dismiss
ROUND_TICKS, 100, cycles allowed per round before timeout (>=2)
SETTLE, 4, cycles SPDTs must equal target to score (>=1)
CWIDTH, 16, width of streak counter output
MWIDTH, 8, width of saturating miss counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
alarm_ring  in  1  level; high while alarm is sounding
random_led  in  N_SW  one-hot candidate target from random generator
SPDTs  in  N_SW  switch inputs, pre-synchronised
mini_game  out  1  high while game active (any state except IDLE, WAIT_CLR)
target_led  out  N_SW  current target; 0 when not in SHOW/HOLD
count_state  out  CWIDTH  current consecutive-correct streak
miss_count  out  MWIDTH  misses since game start, saturating at all-ones
miss_pulse  out  1  one-cycle pulse per miss (wrong switch or timeout)
game_done  out  1  one-cycle pulse when WIN_COUNT reached

Behaviour:
- Reset (sync, active-high, overrides everything): state IDLE; all outputs 0; timers, streak, and round index cleared.
- States: IDLE, ARM, SHOW, HOLD, RELEASE, DONE, WAIT_CLR. All outputs are registered.
- IDLE: alarm_ring=1 -> ARM. mini_game rises the next cycle. Streak and miss_count are cleared on entry to ARM.
- ARM: wait for SPDTs==0 -> SHOW.
- Target latch on every SHOW entry from ARM or RELEASE:
  - If random_led is exactly one-hot, target = random_led.
  - Otherwise, target = 1 << (round_idx mod N_SW).
  - round_idx increments per latch. The round timer clears to 0.
- SHOW: the round timer increments each cycle.
  - SPDTs==target -> HOLD, settle count = 1.
  - SPDTs nonzero and != target -> miss.
  - Timer reaches ROUND_TICKS-1 with no match -> miss (timeout).
  - Match and timeout in the same cycle: the match wins.
- HOLD: the round timer keeps running but a timeout does not apply.
  - SPDTs==target -> settle+1. When settle reaches SETTLE, score.
  - SPDTs==0 -> back to SHOW; the timer is not cleared.
  - Other nonzero value -> miss.
- Score: streak+1.
  - If the new streak == WIN_COUNT -> DONE.
  - Else -> RELEASE.
- Miss: streak <- 0; miss_count+1 (saturating); miss_pulse for 1 cycle; -> RELEASE.
- RELEASE: target_led=0. SPDTs==0 -> SHOW with a new target.
- DONE: game_done=1 for exactly one cycle; mini_game=0 from the next cycle; -> WAIT_CLR. Streak holds WIN_COUNT until the next ARM.
- WAIT_CLR: stay until alarm_ring=0 -> IDLE. This prevents an immediate restart while the ring is still high.
- Abort: alarm_ring=0 in ARM/SHOW/HOLD/RELEASE -> IDLE next cycle.
  - mini_game, target_led, and streak go to 0.
  - No game_done; miss_count is held.
- Latency: from the SETTLE-th matching cycle, count_state updates at the next clock edge.
- Width rules: comparisons are over the full N_SW bits. The streak counter never exceeds WIN_COUNT. WIN_COUNT must fit in CWIDTH (elaboration check).

Decomposition:
- Shared package service_4_pkg:
  - state encoding localparams (one-hot, 7 bits)
  - default N_SW, CWIDTH, MWIDTH
  - function is_onehot(vector)
- One sub-module: service_4_round_timer. It holds the round timer and settle counter with clear/enable/terminal-count outputs, parametrised by ROUND_TICKS and SETTLE.
- The FSM and counters stay in the top module.

Test Plan:
- Win path (defaults): ring=1, random_led=10'b1; per round, set SPDTs=target for 4 cycles, then SPDTs=0 -> count_state 1,2,3; game_done pulses once; mini_game drops one cycle later.
- Wrong switch: target=10'b100000, SPDTs=10'b010000 -> miss_pulse once, miss_count=1, count_state=0; RELEASE until SPDTs=0.
- Timeout: ROUND_TICKS=100, no switch activity -> miss exactly 99 cycles after SHOW entry; miss_count increments; a new target is latched after release.
- Settle bounce: SPDTs=target for 2 cycles, then 0, then target for 4 cycles -> exactly one score, no miss.
- Non-one-hot random_led=10'b0 at round 3 -> target=10'b100 (round_idx=2 fallback).
- Abort and reset: alarm_ring drops during HOLD -> IDLE next cycle, no game_done. Reset asserted mid-SHOW -> all outputs 0 on the next edge. A ring held high after DONE does not restart the game until it toggles low then high.
